// File: rtl/vga_display_ctrl.sv
// vga_display_ctrl: 640x480@60 VGA timing generator that reads two 256x256
// RGB444 images from video memory and shows them side by side. The memory
// read address comes straight from the counters; sync, blank and colour are
// registered twice so every pin lines up with the 1-cycle memory read latency.
// Optional build macro: VGA_BORDER_EN draws a one-pixel white frame around
// each image.
module vga_display_ctrl #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_X0   = 64,
  parameter int unsigned IMG_Y0   = 112,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [16:0] raddr,
  input  logic [11:0] rdata,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0]  H_VIS_C = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_C = 10'(V_VIS);
  localparam logic [9:0]  HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [10:0] X0      = 11'(IMG_X0);
  localparam logic [10:0] Y0      = 11'(IMG_Y0);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;

  // Stage 0 (combinational from counters)
  logic [10:0] hx, vy;
  logic [8:0]  xr;
  logic [7:0]  yr;
  logic        vis0, hs0, vs0, in_img0, fs0;

  // Stage 1
  logic        vis1_q, hs1_q, vs1_q, img1_q;

  // Stage 2 / outputs
  logic        hs_q, vs_q, blank_n_q, fs_q;
  logic [11:0] rgb_q, rgb_d;

  // Next raster position: h wraps every line, v advances on the h wrap
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  // Raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0 decode and memory address; offsets below the image origin wrap
  // to large unsigned values so a single upper-bound compare covers both ends
  always_comb begin
    hx      = {1'b0, h_cnt_q} - X0;
    vy      = {1'b0, v_cnt_q} - Y0;
    xr      = hx[8:0];
    yr      = vy[7:0];
    vis0    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    hs0     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs0     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    in_img0 = (hx < 11'd512) && (vy < 11'd256);
    fs0     = (h_cnt_q == '0) && (v_cnt_q == '0);
    raddr   = in_img0 ? {xr[8], yr, xr[7:0]} : '0;
  end

`ifdef VGA_BORDER_EN
  logic [10:0] bx, by;
  logic        border0, border1_q;

  // Border ring: the image rectangle grown by one pixel on every side,
  // minus the image itself
  always_comb begin
    bx      = {1'b0, h_cnt_q} - X0 + 11'd1;
    by      = {1'b0, v_cnt_q} - Y0 + 11'd1;
    border0 = (bx < 11'd514) && (by < 11'd258) && !in_img0;
  end

  // Border flag travels with the other stage-1 flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) border1_q <= 1'b0;
    else        border1_q <= border0;
  end
`endif

  // Stage 1: delay the decode by one cycle so it meets the memory read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      img1_q <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      vis1_q <= vis0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
      img1_q <= in_img0;
      fs_q   <= fs0;
    end
  end

  // Colour select: black outside the visible area, memory data inside the images
  always_comb begin
    rgb_d = BG_COLOR;
    if (!vis1_q) begin
      rgb_d = '0;
    end else if (img1_q) begin
      rgb_d = rdata;
    end
`ifdef VGA_BORDER_EN
    else if (border1_q) begin
      rgb_d = '1;
    end
`endif
  end

  // Stage 2: registered pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hs1_q;
      vs_q      <= vs1_q;
      blank_n_q <= vis1_q;
      rgb_q     <= rgb_d;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Bench for vga_display_ctrl. The vertical timing is shortened (40 visible
// lines, 50 total, image origin at line 4) so that a full frame plus a
// mid-frame reset fit in a short run; horizontal timing is the real 800-clock
// line. BG_COLOR is non-zero so background and blanking are distinguishable.
module tb_vga_display_ctrl;

  localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_VIS = 40,  V_FP = 3,  V_SYNC = 2,  V_BP = 5;
  localparam int IMG_X0 = 64, IMG_Y0 = 4;
  localparam logic [11:0] BG = 12'h123;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 800
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 50
  localparam int FRAME = H_TOT * V_TOT;                  // 40000

  logic        clk, rst_n;
  logic [16:0] raddr;
  logic [11:0] rdata;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;
  int fs_hits = 0, fs_first = -1, fs_second = -1, fs_last = -1;
  int hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  vga_display_ctrl #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Memory model: registered read, data = low 12 address bits
  always @(posedge clk) rdata <= raddr[11:0];

  // Clock edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // ---------------- model: raster position n -> expected values ----------
  function automatic int hc(input int n); return n % H_TOT; endfunction
  function automatic int vc(input int n); return (n / H_TOT) % V_TOT; endfunction

  function automatic logic [16:0] addr_at(input int n);
    int xr, yr;
    xr = hc(n) - IMG_X0;
    yr = vc(n) - IMG_Y0;
    if (xr >= 0 && xr < 512 && yr >= 0 && yr < 256)
      return 17'((xr / 256) * 65536 + yr * 256 + (xr % 256));
    return 17'd0;
  endfunction

  function automatic logic [11:0] rgb_at(input int n);
    int xr, yr;
    logic [16:0] a;
    xr = hc(n) - IMG_X0;
    yr = vc(n) - IMG_Y0;
    if (!(hc(n) < H_VIS && vc(n) < V_VIS)) return 12'h000;
    if (xr >= 0 && xr < 512 && yr >= 0 && yr < 256) begin
      a = addr_at(n);
      return a[11:0];
    end
`ifdef VGA_BORDER_EN
    if (xr >= -1 && xr <= 512 && yr >= -1 && yr <= 256) return 12'hFFF;
`endif
    return BG;
  endfunction

  function automatic logic hs_at(input int n);
    return !(hc(n) >= H_VIS + H_FP && hc(n) < H_VIS + H_FP + H_SYNC);
  endfunction
  function automatic logic vs_at(input int n);
    return !(vc(n) >= V_VIS + V_FP && vc(n) < V_VIS + V_FP + V_SYNC);
  endfunction

  // ---------------- per-cycle compare against the model ------------------
  always @(negedge clk) begin
    logic [16:0] e_addr;
    logic [11:0] e_rgb, a_rgb;
    logic        e_hs, e_vs, e_bl, e_fs;
    int k;
    k      = edges;
    e_addr = addr_at(k);
    if (k >= 2) begin
      e_rgb = rgb_at(k - 2);
      e_hs  = hs_at(k - 2);
      e_vs  = vs_at(k - 2);
      e_bl  = (hc(k - 2) < H_VIS) && (vc(k - 2) < V_VIS);
    end else begin
      e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
    end
    e_fs  = (k >= 1) && (((k - 1) % FRAME) == 0);
    a_rgb = {vga_r, vga_g, vga_b};
    n_tests++;
    if (raddr !== e_addr || a_rgb !== e_rgb || vga_hs !== e_hs || vga_vs !== e_vs ||
        vga_blank_n !== e_bl || frame_start !== e_fs) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL model edge=%0d: raddr=%h/%h rgb=%h/%h hs=%b/%b vs=%b/%b blank_n=%b/%b fs=%b/%b (got/want)",
                 k, raddr, e_addr, a_rgb, e_rgb, vga_hs, e_hs, vga_vs, e_vs,
                 vga_blank_n, e_bl, frame_start, e_fs);
    end
    if (rst_n) begin
      if (prev_hs && !vga_hs && hs_fall < 0) hs_fall = k;
      if (!prev_hs && vga_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = k;
      if (prev_vs && !vga_vs && vs_fall < 0) vs_fall = k;
      if (!prev_vs && vga_vs && vs_fall >= 0 && vs_rise < 0) vs_rise = k;
      if (frame_start) begin
        fs_hits++;
        fs_last = k;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
    end
    prev_hs = vga_hs;
    prev_vs = vga_vs;
  end

  // ---------------- literal checks ---------------------------------------
  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run_to(input int k);
    for (int i = 0; i < 50000 && edges < k; i++) @(negedge clk);
    if (edges != k) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_to: edge counter %0d, wanted %0d", edges, k);
    end
  endtask

  int hits_before;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset raddr", 17'(raddr), 17'h0);
    chk("reset rgb", 17'({vga_r, vga_g, vga_b}), 17'h0);
    chk("reset hs/vs/blank/fs", 17'({vga_hs, vga_vs, vga_blank_n, frame_start}), 17'b1100);
    rst_n = 1'b1;

    run_to(3264);  chk("raddr (64,4)",   17'(raddr), 17'h00000);
    run_to(3519);  chk("raddr (319,4)",  17'(raddr), 17'h000FF);
    run_to(4320);  chk("raddr (320,5)",  17'(raddr), 17'h10100);
    run_to(8010);  chk("raddr (10,10)",  17'(raddr), 17'h00000);
    run_to(8012);  chk("rgb (10,10)",    17'({vga_r, vga_g, vga_b}), 17'(BG));
                   chk("blank (10,10)",  17'(vga_blank_n), 17'h1);
    run_to(8702);  chk("rgb (700,10)",   17'({vga_r, vga_g, vga_b}), 17'h000);
                   chk("blank (700,10)", 17'(vga_blank_n), 17'h0);
    run_to(24065);
`ifdef VGA_BORDER_EN
    chk("rgb (63,30) border", 17'({vga_r, vga_g, vga_b}), 17'hFFF);
`else
    chk("rgb (63,30) bg", 17'({vga_r, vga_g, vga_b}), 17'(BG));
`endif
    run_to(24100); chk("raddr (100,30)", 17'(raddr), 17'h01A24);
    run_to(24101); chk("rgb (99,30)",    17'({vga_r, vga_g, vga_b}), 17'hA23);
    run_to(24102); chk("rgb (100,30)",   17'({vga_r, vga_g, vga_b}), 17'hA24);
    run_to(24103); chk("rgb (101,30)",   17'({vga_r, vga_g, vga_b}), 17'hA25);
    run_to(24600); chk("raddr (600,30)", 17'(raddr), 17'h00000);
    run_to(24602); chk("rgb (600,30)",   17'({vga_r, vga_g, vga_b}), 17'(BG));
    run_to(31775); chk("raddr (575,39)", 17'(raddr), 17'h123FF);
    run_to(40010);
    chk("hsync fall edge", 17'(hs_fall), 17'd658);
    chk("hsync rise edge", 17'(hs_rise), 17'd754);
    chk("vsync fall edge", 17'(vs_fall), 17'd34402);
    chk("vsync rise edge", 17'(vs_rise), 17'd36002);
    chk("first frame_start", 17'(fs_first), 17'd1);
    chk("frame period", 17'(fs_second - fs_first), 17'd40000);

    // Mid-line reset at (300,5) of the second frame
    run_to(FRAME + 4300);
    #5 rst_n = 1'b0;
    #1;
    chk("async reset raddr", 17'(raddr), 17'h0);
    chk("async reset rgb", 17'({vga_r, vga_g, vga_b}), 17'h0);
    chk("async reset hs/vs/blank/fs", 17'({vga_hs, vga_vs, vga_blank_n, frame_start}), 17'b1100);
    @(negedge clk);
    hits_before = fs_hits;
    rst_n = 1'b1;
    run_to(2000);
    chk("frame_start pulses after reset", 17'(fs_hits - hits_before), 17'd1);
    chk("frame_start edge after reset", 17'(fs_last), 17'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
